// File: rtl/proc_x_stage.sv
// Execute stage: ALU for arithmetic/logic ops plus a serial
// one-bit-per-cycle shifter that stalls decode while it runs.
module proc_x_stage #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_valid,
  output logic            x_ready,
  input  logic            flush,
  input  logic [1:0]      alu_sel,
  input  logic [2:0]      alu_op,
  input  logic            op1_sel,
  input  logic            op2_sel,
  input  logic [XLEN-1:0] reg1_data,
  input  logic [XLEN-1:0] reg2_data,
  input  logic [XLEN-1:0] pc_val_d2,
  input  logic [XLEN-1:0] imm_signed,
  input  logic [4:0]      rd_addr,
  input  logic            rd_wen,
  output logic            w_valid,
  output logic [XLEN-1:0] w_result,
  output logic [4:0]      w_rd_addr,
  output logic            w_rd_wen
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
  logic [1:0]      kind;
  logic [4:0]      s_rd;
  logic            s_wen;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            slt;
  logic            sltu;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] acc_nxt;

  assign x_ready = (state == IDLE);

  assign op1   = op1_sel ? pc_val_d2 : reg1_data;
  assign op2   = op2_sel ? imm_signed : reg2_data;
  assign shamt = op2[SHW-1:0];
  assign slt   = $signed(op1) < $signed(op2);
  assign sltu  = op1 < op2;

  // Only the three defined shift sub-ops go to the serial shifter
  assign is_shift = (alu_sel == 2'd2) && (alu_op <= 3'd2);

  // Single-cycle result; a zero-distance shift is just op1
  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      alu_sel == 2'd0: begin
        case (alu_op)
          3'd0:    alu_res = op1 + op2;
          3'd1:    alu_res = op1 - op2;
          3'd2:    alu_res = {{(XLEN-1){1'b0}}, slt};
          3'd3:    alu_res = {{(XLEN-1){1'b0}}, sltu};
          default: alu_res = '0;
        endcase
      end
      alu_sel == 2'd1: begin
        case (alu_op)
          3'd0:    alu_res = op1 & op2;
          3'd1:    alu_res = op1 | op2;
          3'd2:    alu_res = op1 ^ op2;
          default: alu_res = '0;
        endcase
      end
      alu_sel == 2'd2: begin
        alu_res = is_shift ? op1 : '0;
      end
      default: alu_res = '0;
    endcase
  end

  // One shift step of the accumulator
  always_comb begin
    acc_nxt = acc;
    case (kind)
      2'd0:    acc_nxt = {acc[XLEN-2:0], 1'b0};
      2'd1:    acc_nxt = {1'b0, acc[XLEN-1:1]};
      2'd2:    acc_nxt = {acc[XLEN-1], acc[XLEN-1:1]};
      default: acc_nxt = acc;
    endcase
  end

  // Control FSM with registered writeback outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      kind      <= '0;
      s_rd      <= '0;
      s_wen     <= 1'b0;
      w_valid   <= 1'b0;
      w_result  <= '0;
      w_rd_addr <= '0;
      w_rd_wen  <= 1'b0;
    end else begin
      w_valid  <= 1'b0;
      w_rd_wen <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (d_valid) begin
              if (is_shift && (shamt != '0)) begin
                state <= SHIFT;
                acc   <= op1;
                cnt   <= shamt;
                kind  <= alu_op[1:0];
                s_rd  <= rd_addr;
                s_wen <= rd_wen;
              end else begin
                w_valid   <= 1'b1;
                w_result  <= alu_res;
                w_rd_addr <= rd_addr;
                w_rd_wen  <= rd_wen;
              end
            end
          end
          SHIFT: begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == SHW'(1)) begin
              state     <= IDLE;
              w_valid   <= 1'b1;
              w_result  <= acc_nxt;
              w_rd_addr <= s_rd;
              w_rd_wen  <= s_wen;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_proc_x_stage.sv
// Scoreboard bench for proc_x_stage: directed vectors push expected
// results; a negedge monitor pops and compares on every w_valid.
module tb_proc_x_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            d_valid = 1'b0;
  logic            x_ready;
  logic            flush = 1'b0;
  logic [1:0]      alu_sel = '0;
  logic [2:0]      alu_op = '0;
  logic            op1_sel = 1'b0;
  logic            op2_sel = 1'b0;
  logic [XLEN-1:0] reg1_data = '0;
  logic [XLEN-1:0] reg2_data = '0;
  logic [XLEN-1:0] pc_val_d2 = '0;
  logic [XLEN-1:0] imm_signed = '0;
  logic [4:0]      rd_addr = '0;
  logic            rd_wen = 1'b0;
  logic            w_valid;
  logic [XLEN-1:0] w_result;
  logic [4:0]      w_rd_addr;
  logic            w_rd_wen;

  proc_x_stage #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_valid    (d_valid),
    .x_ready    (x_ready),
    .flush      (flush),
    .alu_sel    (alu_sel),
    .alu_op     (alu_op),
    .op1_sel    (op1_sel),
    .op2_sel    (op2_sel),
    .reg1_data  (reg1_data),
    .reg2_data  (reg2_data),
    .pc_val_d2  (pc_val_d2),
    .imm_signed (imm_signed),
    .rd_addr    (rd_addr),
    .rd_wen     (rd_wen),
    .w_valid    (w_valid),
    .w_result   (w_result),
    .w_rd_addr  (w_rd_addr),
    .w_rd_wen   (w_rd_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    logic            wen;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [XLEN-1:0] act,
                       logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every w_valid must match the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (w_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: cyc %0d result %h",
                   cyc, w_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (w_result !== e.res || w_rd_addr !== e.rd ||
              w_rd_wen !== e.wen || cyc != e.cyc) begin
            errors++;
            $display("FAIL result: got %h/%0d/%0b@%0d expected %h/%0d/%0b@%0d",
                     w_result, w_rd_addr, w_rd_wen, cyc,
                     e.res, e.rd, e.wen, e.cyc);
          end
        end
      end else if (w_rd_wen) begin
        checks++;
        errors++;
        $display("FAIL wen_without_valid: got 1 expected 0");
      end
    end
  end

  // Present one instruction in the current cycle (called at negedge)
  task automatic present(logic [1:0] s, logic [2:0] o, logic o1s,
                         logic o2s, logic [XLEN-1:0] r1,
                         logic [XLEN-1:0] r2, logic [XLEN-1:0] pc,
                         logic [XLEN-1:0] im, logic [4:0] rd,
                         logic wen);
    d_valid    = 1'b1;
    alu_sel    = s;
    alu_op     = o;
    op1_sel    = o1s;
    op2_sel    = o2s;
    reg1_data  = r1;
    reg2_data  = r2;
    pc_val_d2  = pc;
    imm_signed = im;
    rd_addr    = rd;
    rd_wen     = wen;
  endtask

  task automatic expect_res(logic [XLEN-1:0] res, logic [4:0] rd,
                            logic wen, int lat);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    e.wen = wen;
    e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  int c0;
  int waited;

  initial begin
    #1;
    check("rst_w_valid", {31'd0, w_valid}, 32'd0);
    check("rst_w_result", w_result, 32'd0);
    check("rst_w_rd_addr", {27'd0, w_rd_addr}, 32'd0);
    check("rst_w_rd_wen", {31'd0, w_rd_wen}, 32'd0);
    check("rst_x_ready", {31'd0, x_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ADD wraps
    present(2'd0, 3'd0, 0, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 5'd5, 1);
    expect_res(32'h0, 5'd5, 1'b1, 1);
    step();
    // SLT / SLTU with immediate, back to back
    present(2'd0, 3'd2, 0, 1, 32'hFFFFFFFF, 0, 0, 32'd1, 5'd6, 1);
    expect_res(32'd1, 5'd6, 1'b1, 1);
    @(negedge clk);
    present(2'd0, 3'd3, 0, 1, 32'hFFFFFFFF, 0, 0, 32'd1, 5'd7, 1);
    expect_res(32'd0, 5'd7, 1'b1, 1);
    @(negedge clk);
    // PC-relative ADD
    present(2'd0, 3'd0, 1, 1, 0, 0, 32'h1000, 32'hFFFFFFFC, 5'd8, 1);
    expect_res(32'h00000FFC, 5'd8, 1'b1, 1);
    @(negedge clk);
    // SUB, AND, OR (wen=0), illegal group
    present(2'd0, 3'd1, 0, 0, 32'd5, 32'd7, 0, 0, 5'd9, 1);
    expect_res(32'hFFFFFFFE, 5'd9, 1'b1, 1);
    @(negedge clk);
    present(2'd1, 3'd0, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 5'd10, 1);
    expect_res(32'h00F0, 5'd10, 1'b1, 1);
    @(negedge clk);
    present(2'd1, 3'd1, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 5'd11, 0);
    expect_res(32'hFFF0, 5'd11, 1'b0, 1);
    @(negedge clk);
    present(2'd3, 3'd0, 0, 0, 32'h1234, 32'h1, 0, 0, 5'd12, 1);
    expect_res(32'h0, 5'd12, 1'b1, 1);
    step();
    @(negedge clk);

    // SRA by 4 (imm 0x24: upper shamt bits ignored)
    present(2'd2, 3'd2, 0, 1, 32'h80000010, 0, 0, 32'h24, 5'd13, 1);
    expect_res(32'hF8000001, 5'd13, 1'b1, 5);
    step();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("sra_stall_c%0d", i), {31'd0, x_ready}, 32'd0);
      @(negedge clk);
    end
    check("sra_ready_c5", {31'd0, x_ready}, 32'd1);
    // shamt=0 variant via reg2=0x20
    present(2'd2, 3'd2, 0, 0, 32'h80000010, 32'h20, 0, 0, 5'd14, 1);
    expect_res(32'h80000010, 5'd14, 1'b1, 1);
    step();
    @(negedge clk);

    // SLL by 31 then XOR held on d_valid
    c0 = cyc;
    present(2'd2, 3'd0, 0, 0, 32'd1, 32'd31, 0, 0, 5'd15, 1);
    expect_res(32'h80000000, 5'd15, 1'b1, 32);
    @(negedge clk);
    present(2'd1, 3'd2, 0, 0, 32'hF0F0, 32'h0FF0, 0, 0, 5'd16, 1);
    expect_res(32'hFF00, 5'd16, 1'b1, 32);
    waited = 0;
    while (!x_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("xor_accept_cycle", cyc - c0, 32);
    step();
    @(negedge clk);

    // SRL by 10 flushed in cycle 3
    c0 = cyc;
    present(2'd2, 3'd1, 0, 0, 32'hFFFF0000, 32'd10, 0, 0, 5'd17, 1);
    step();
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready_c4", {31'd0, x_ready}, 32'd1);
    check("flush_no_valid", {31'd0, w_valid}, 32'd0);
    repeat (12) @(negedge clk);

    // flush together with a presented instruction in IDLE
    present(2'd0, 3'd0, 0, 0, 32'd1, 32'd2, 0, 0, 5'd18, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle_no_valid", {31'd0, w_valid}, 32'd0);
    @(negedge clk);

    // result after flush still works
    present(2'd1, 3'd2, 0, 0, 32'hA5, 32'h0F, 0, 0, 5'd19, 1);
    expect_res(32'hAA, 5'd19, 1'b1, 1);
    step();
    @(negedge clk);

    // SRL by 10 killed by reset in cycle 5
    present(2'd2, 3'd1, 0, 0, 32'hFFFF0000, 32'd10, 0, 0, 5'd20, 1);
    step();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_w_valid", {31'd0, w_valid}, 32'd0);
    check("rst_mid_w_result", w_result, 32'd0);
    check("rst_mid_w_rd_addr", {27'd0, w_rd_addr}, 32'd0);
    check("rst_mid_w_rd_wen", {31'd0, w_rd_wen}, 32'd0);
    check("rst_mid_x_ready", {31'd0, x_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
